bicubic_weight_gen: RTL and testbench

//  Streaming generator of all four bicubic tap weights (w0..w3) for one fractional phase t and kernel coefficient a = -A.

---
 rtl/bicubic_weight_gen.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_bicubic_weight_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_weight_gen.sv
// bicubic_weight_gen: streaming generator of the four bicubic tap weights for phase t and A = -a.
// Define BICUBIC_WSUM_FIX_EN to add a fifth stage that forces the weight sum to exactly 1.0.
module bicubic_weight_gen #(
    parameter int FRAC  = 8,
    parameter int OUT_W = 10,
    parameter int TAG_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FRAC-1:0]         in_phase,
    input  logic [FRAC:0]           in_a,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_w0,
    output logic signed [OUT_W-1:0] out_w1,
    output logic signed [OUT_W-1:0] out_w2,
    output logic signed [OUT_W-1:0] out_w3,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int PW = 4 * FRAC + 4;

    localparam logic [FRAC:0]        A_MAX     = {1'b1, {FRAC{1'b0}}};
    localparam logic signed [PW-1:0] ONE_P     = {{(PW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [PW-1:0] TWO_P     = ONE_P <<< 1;
    localparam logic signed [PW-1:0] THREE_P   = ONE_P + TWO_P;
    localparam logic signed [PW-1:0] ONE2_P    = ONE_P <<< FRAC;
    localparam logic signed [PW-1:0] ONE4_P    = ONE_P <<< (3 * FRAC);
    localparam logic signed [PW-1:0] HALF_P    = ONE_P <<< (2 * FRAC - 1);
    localparam logic signed [PW-1:0] SAT_MAX_P = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN_P = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Polynomials are kept at 4*FRAC fractional bits; rounding once at 3*FRAC is
    // bit-identical to truncating to 3*FRAC and then rounding half up at 2*FRAC.
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] r;
        r = (v + HALF_P) >>> (3 * FRAC);
        if (r > SAT_MAX_P)
            r = SAT_MAX_P;
        else if (r < SAT_MIN_P)
            r = SAT_MIN_P;
        return r[OUT_W-1:0];
    endfunction

    logic en;

    logic             v1_q, v1_d;
    logic [FRAC-1:0]  t1_q, t1_d;
    logic [FRAC:0]    a1_q, a1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    logic              v2_q, v2_d;
    logic [FRAC-1:0]   t2_q, t2_d;
    logic [FRAC:0]     a2_q, a2_d;
    logic [2*FRAC-1:0] tsq2_q, tsq2_d;
    logic [FRAC:0]     omt2_q, omt2_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;

    logic                 v3_q, v3_d;
    logic signed [PW-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [TAG_W-1:0]     tag3_q, tag3_d;
    logic signed [PW-1:0] tp, ap, sp, op, t3p;

    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_w0_q, out_w0_d, out_w1_q, out_w1_d;
    logic signed [OUT_W-1:0] out_w2_q, out_w2_d, out_w3_q, out_w3_d;
    logic [TAG_W-1:0]        out_tag_q, out_tag_d;

    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_w0    = out_w0_q;
    assign out_w1    = out_w1_q;
    assign out_w2    = out_w2_q;
    assign out_w3    = out_w3_q;
    assign out_tag   = out_tag_q;

    always_comb begin
        v1_d   = v1_q;
        t1_d   = t1_q;
        a1_d   = a1_q;
        tag1_d = tag1_q;
        if (en) begin
            v1_d   = in_valid;
            t1_d   = in_phase;
            a1_d   = (in_a > A_MAX) ? A_MAX : in_a;
            tag1_d = in_tag;
        end
    end

    always_comb begin
        v2_d   = v2_q;
        t2_d   = t2_q;
        a2_d   = a2_q;
        tsq2_d = tsq2_q;
        omt2_d = omt2_q;
        tag2_d = tag2_q;
        if (en) begin
            v2_d   = v1_q;
            t2_d   = t1_q;
            a2_d   = a1_q;
            tsq2_d = {{FRAC{1'b0}}, t1_q} * {{FRAC{1'b0}}, t1_q};
            omt2_d = A_MAX - {1'b0, t1_q};
            tag2_d = tag1_q;
        end
    end

    // All four polynomials are exact integers; their sum is exactly 1.0 at this scale.
    always_comb begin
        tp     = {{(PW-FRAC){1'b0}}, t2_q};
        ap     = {{(PW-FRAC-1){1'b0}}, a2_q};
        sp     = {{(PW-2*FRAC){1'b0}}, tsq2_q};
        op     = {{(PW-FRAC-1){1'b0}}, omt2_q};
        t3p    = sp * tp;
        v3_d   = v3_q;
        p0_d   = p0_q;
        p1_d   = p1_q;
        p2_d   = p2_q;
        p3_d   = p3_q;
        tag3_d = tag3_q;
        if (en) begin
            v3_d   = v2_q;
            p0_d   = -(ap * tp * op * op);
            p1_d   = (TWO_P - ap) * t3p - (THREE_P - ap) * sp * ONE_P + ONE4_P;
            p2_d   = (ap - TWO_P) * t3p + (THREE_P - (ap <<< 1)) * sp * ONE_P + ap * tp * ONE2_P;
            p3_d   = -(ap * sp * op);
            tag3_d = tag2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            t1_q   <= '0;
            a1_q   <= '0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            t2_q   <= '0;
            a2_q   <= '0;
            tsq2_q <= '0;
            omt2_q <= '0;
            tag2_q <= '0;
            v3_q   <= 1'b0;
            p0_q   <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            tag3_q <= '0;
        end else begin
            v1_q   <= v1_d;
            t1_q   <= t1_d;
            a1_q   <= a1_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            t2_q   <= t2_d;
            a2_q   <= a2_d;
            tsq2_q <= tsq2_d;
            omt2_q <= omt2_d;
            tag2_q <= tag2_d;
            v3_q   <= v3_d;
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            p3_q   <= p3_d;
            tag3_q <= tag3_d;
        end
    end

`ifdef BICUBIC_WSUM_FIX_EN
    localparam int SW = OUT_W + 3;
    localparam logic signed [SW-1:0] ONE_S     = {{(SW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX_S = {4'b0000, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN_S = {4'b1111, {(OUT_W-1){1'b0}}};

    function automatic logic signed [SW-1:0] sx(input logic signed [OUT_W-1:0] w);
        return {{3{w[OUT_W-1]}}, w};
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_w(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = v;
        if (r > SAT_MAX_S)
            r = SAT_MAX_S;
        else if (r < SAT_MIN_S)
            r = SAT_MIN_S;
        return r[OUT_W-1:0];
    endfunction

    logic                    hi2_q, hi2_d, hi3_q, hi3_d, hi4_q, hi4_d;
    logic                    v4_q, v4_d;
    logic signed [OUT_W-1:0] w0_4q, w0_4d, w1_4q, w1_4d, w2_4q, w2_4d, w3_4q, w3_4d;
    logic [TAG_W-1:0]        tag4_q, tag4_d;
    logic signed [SW-1:0]    sum5, r5;

    always_comb begin
        hi2_d  = hi2_q;
        hi3_d  = hi3_q;
        hi4_d  = hi4_q;
        v4_d   = v4_q;
        w0_4d  = w0_4q;
        w1_4d  = w1_4q;
        w2_4d  = w2_4q;
        w3_4d  = w3_4q;
        tag4_d = tag4_q;
        if (en) begin
            hi2_d  = t1_q[FRAC-1];
            hi3_d  = hi2_q;
            hi4_d  = hi3_q;
            v4_d   = v3_q;
            w0_4d  = round_sat(p0_q);
            w1_4d  = round_sat(p1_q);
            w2_4d  = round_sat(p2_q);
            w3_4d  = round_sat(p3_q);
            tag4_d = tag3_q;
        end
    end

    // The rounding residue goes to the centre tap nearest the sample point.
    always_comb begin
        sum5        = sx(w0_4q) + sx(w1_4q) + sx(w2_4q) + sx(w3_4q);
        r5          = ONE_S - sum5;
        out_valid_d = out_valid_q;
        out_w0_d    = out_w0_q;
        out_w1_d    = out_w1_q;
        out_w2_d    = out_w2_q;
        out_w3_d    = out_w3_q;
        out_tag_d   = out_tag_q;
        if (en) begin
            out_valid_d = v4_q;
            out_w0_d    = w0_4q;
            out_w1_d    = hi4_q ? w1_4q : sat_w(sx(w1_4q) + r5);
            out_w2_d    = hi4_q ? sat_w(sx(w2_4q) + r5) : w2_4q;
            out_w3_d    = w3_4q;
            out_tag_d   = tag4_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi2_q  <= 1'b0;
            hi3_q  <= 1'b0;
            hi4_q  <= 1'b0;
            v4_q   <= 1'b0;
            w0_4q  <= '0;
            w1_4q  <= '0;
            w2_4q  <= '0;
            w3_4q  <= '0;
            tag4_q <= '0;
        end else begin
            hi2_q  <= hi2_d;
            hi3_q  <= hi3_d;
            hi4_q  <= hi4_d;
            v4_q   <= v4_d;
            w0_4q  <= w0_4d;
            w1_4q  <= w1_4d;
            w2_4q  <= w2_4d;
            w3_4q  <= w3_4d;
            tag4_q <= tag4_d;
        end
    end
`else
    always_comb begin
        out_valid_d = out_valid_q;
        out_w0_d    = out_w0_q;
        out_w1_d    = out_w1_q;
        out_w2_d    = out_w2_q;
        out_w3_d    = out_w3_q;
        out_tag_d   = out_tag_q;
        if (en) begin
            out_valid_d = v3_q;
            out_w0_d    = round_sat(p0_q);
            out_w1_d    = round_sat(p1_q);
            out_w2_d    = round_sat(p2_q);
            out_w3_d    = round_sat(p3_q);
            out_tag_d   = tag3_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_w0_q    <= '0;
            out_w1_q    <= '0;
            out_w2_q    <= '0;
            out_w3_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_w0_q    <= out_w0_d;
            out_w1_q    <= out_w1_d;
            out_w2_q    <= out_w2_d;
            out_w3_q    <= out_w3_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_bicubic_weight_gen.sv
// Self-checking bench for bicubic_weight_gen: directed table, stall/reset sequences and
// randomized streams scored against a bicubic-kernel reference model.
module tb_bicubic_weight_gen;
    localparam int FRAC  = 8;
    localparam int OUT_W = 10;
    localparam int TAG_W = 16;
`ifdef BICUBIC_WSUM_FIX_EN
    localparam int LATENCY = 5;
`else
    localparam int LATENCY = 4;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [FRAC-1:0]         in_phase;
    logic [FRAC:0]           in_a;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_w0, out_w1, out_w2, out_w3;
    logic [TAG_W-1:0]        out_tag;

    bicubic_weight_gen #(.FRAC(FRAC), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_phase(in_phase), .in_a(in_a), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_w0(out_w0), .out_w1(out_w1), .out_w2(out_w2), .out_w3(out_w3),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct { int w0; int w1; int w2; int w3; int tag; } exp_t;
    typedef struct { int t; int a; int e0; int e1; int e2; int e3; } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rx_cnt = 0;
    int   stall_cnt = 0;
    bit   mon_en = 1'b0;
    bit   was_stall = 1'b0;
    logic [4*OUT_W+TAG_W-1:0] snap;
    exp_t exp_q[$];

    task automatic checkOutput(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Keys cubic convolution kernel, a = -A; d = |x| scaled by 2^FRAC, result scaled by 2^(4*FRAC).
    function automatic longint kern(input longint d, input longint aa);
        if (d <= 256)
            return (512 - aa) * d * d * d - (768 - aa) * d * d * 256 + (longint'(1) <<< 32);
        else if (d < 512)
            return -aa * d * d * d + 5 * aa * d * d * 256 - 8 * aa * d * 65536 + 4 * aa * (longint'(1) <<< 24);
        else
            return 0;
    endfunction

    function automatic int satW(input longint v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return int'(v);
    endfunction

    function automatic int roundW(input longint v);
        return satW((v + (longint'(1) <<< 23)) >>> 24);
    endfunction

    function automatic exp_t modelSet(input int t, input int a, input int tag);
        exp_t   e;
        longint aa;
        aa    = (a > 256) ? 256 : a;
        e.w0  = roundW(kern(256 + t, aa));
        e.w1  = roundW(kern(t, aa));
        e.w2  = roundW(kern(256 - t, aa));
        e.w3  = roundW(kern(512 - t, aa));
        e.tag = tag & 16'hFFFF;
`ifdef BICUBIC_WSUM_FIX_EN
        begin
            int r;
            r = 256 - (e.w0 + e.w1 + e.w2 + e.w3);
            if (t < 128) e.w1 = satW(e.w1 + r);
            else         e.w2 = satW(e.w2 + r);
        end
`endif
        return e;
    endfunction

    // Single isolated transaction; returns cycles from accept until out_valid rises.
    task automatic applyStimulus(input int t, input int a, input int tag, output int lat);
        in_valid = 1'b1;
        in_phase = t[FRAC-1:0];
        in_a     = a[FRAC:0];
        in_tag   = tag[TAG_W-1:0];
        lat      = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            lat = k;
            if (k == 1) in_valid = 1'b0;
            if (out_valid) break;
        end
    endtask

    task automatic sendSet(input int t, input int a, input int tag);
        exp_t e;
        bit   acc;
        e        = modelSet(t, a, tag);
        in_valid = 1'b1;
        in_phase = t[FRAC-1:0];
        in_a     = a[FRAC:0];
        in_tag   = tag[TAG_W-1:0];
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(e);
                return;
            end
        end
        checkOutput("accept timeout", 0, 1);
    endtask

    task automatic drain(input int sent);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("drain residue", exp_q.size(), 0);
        checkOutput("sets received", rx_cnt, sent);
        exp_q.delete();
    endtask

    // Stream scoreboard plus stall stability checks.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (out_valid && out_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL unexpected set: got tag %0d, required none", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("stream w0", int'(out_w0), e.w0);
                    checkOutput("stream w1", int'(out_w1), e.w1);
                    checkOutput("stream w2", int'(out_w2), e.w2);
                    checkOutput("stream w3", int'(out_w3), e.w3);
                    checkOutput("stream tag", int'(out_tag), e.tag);
`ifdef BICUBIC_WSUM_FIX_EN
                    checkOutput("weight sum", int'(out_w0) + int'(out_w1) + int'(out_w2) + int'(out_w3), 256);
`endif
                end
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                checkOutput("stall in_ready", int'(in_ready), 0);
                if (was_stall) begin
                    n_cmp++;
                    if ({out_w0, out_w1, out_w2, out_w3, out_tag} != snap) begin
                        n_bad++;
                        $display("[TB] FAIL stall frozen: got %h, required %h",
                                 {out_w0, out_w1, out_w2, out_w3, out_tag}, snap);
                    end
                end
            end
            was_stall = out_valid && !out_ready;
            snap      = {out_w0, out_w1, out_w2, out_w3, out_tag};
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        int   lat;
        int   seen;
        bit   done;
        int   a_list[4];

        rst = 1'b1; in_valid = 1'b0; in_phase = '0; in_a = '0; in_tag = '0; out_ready = 1'b1;
        vecs[0] = '{0,   128,   0, 256,   0,   0};
        vecs[1] = '{128, 128, -16, 144, 144, -16};
        vecs[2] = '{64,  128, -18, 222,  58,  -6};
        vecs[3] = '{128, 0,     0, 128, 128,   0};
        vecs[4] = '{128, 300, -32, 160, 160, -32};
        vecs[5] = '{128, 256, -32, 160, 160, -32};
        vecs[6] = '{0,   256,   0, 256,   0,   0};
        vecs[7] = '{64,  0,     0, 216,  40,   0};
        vecs[8] = '{192, 128,  -6,  58, 222, -18};

        @(negedge clk);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset in_ready", int'(in_ready), 1);
        checkOutput("reset w0", int'(out_w0), 0);
        checkOutput("reset w1", int'(out_w1), 0);
        checkOutput("reset w2", int'(out_w2), 0);
        checkOutput("reset w3", int'(out_w3), 0);
        checkOutput("reset tag", int'(out_tag), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].t, vecs[i].a, 16'hA000 + i, lat);
            checkOutput("table latency", lat, LATENCY);
            checkOutput("table w0", int'(out_w0), vecs[i].e0);
            checkOutput("table w1", int'(out_w1), vecs[i].e1);
            checkOutput("table w2", int'(out_w2), vecs[i].e2);
            checkOutput("table w3", int'(out_w3), vecs[i].e3);
            checkOutput("table tag", int'(out_tag), 16'hA000 + i);
            @(posedge clk); #1;
        end

        $display("[TB] 32-set burst with 10-cycle output stall");
        mon_en = 1'b1; rx_cnt = 0; stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 32; i++)
                    sendSet($urandom_range(0, 255), $urandom_range(0, 300), 16'h1000 + i);
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(32);
        checkOutput("stall cycles", stall_cnt, 10);

        $display("[TB] randomized stream with random backpressure");
        rx_cnt = 0; done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    sendSet($urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 65535));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        drain(200);

        $display("[TB] phase sweep");
        rx_cnt = 0;
        a_list = '{0, 64, 128, 256};
        for (int ai = 0; ai < 4; ai++)
            for (int t = 0; t < 256; t++)
                sendSet(t, a_list[ai], ai * 256 + t);
        in_valid = 1'b0;
        drain(1024);
        mon_en = 1'b0;

        $display("[TB] reset with sets in flight");
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_phase = 8'(40 * i + 10); in_a = 9'd128; in_tag = 16'(16'h5000 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("flush out_valid", int'(out_valid), 0);
        checkOutput("flush w1", int'(out_w1), 0);
        checkOutput("flush tag", int'(out_tag), 0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("stale sets after reset", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
